// File: rtl/r2r_adc_engine.sv
// R2R-ladder ADC engine: ramp, SAR and delta-tracking conversions sharing one
// step timer and comparator path, followed by a power-of-two block averager.
module r2r_adc_engine #(
    parameter int N_BITS   = 8,
    parameter int STEP_DIV = 100_000,
    parameter int AVG_LOG2 = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              comp_in,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] sample,
    output logic              sample_valid,
    output logic [N_BITS-1:0] avg_code,
    output logic              avg_valid,
    output logic              busy
);

    localparam int STEP_W    = $clog2(STEP_DIV);
    localparam int BIT_W     = $clog2(N_BITS);
    localparam int ACC_W     = N_BITS + AVG_LOG2;
    localparam int AVG_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [N_BITS-1:0]    CODE_MAX  = '1;
    localparam logic [N_BITS-1:0]    CODE_MID  = {1'b1, {(N_BITS-1){1'b0}}};
    localparam logic [BIT_W-1:0]     BIT_TOP   = BIT_W'(N_BITS - 1);
    localparam logic [AVG_CNT_W-1:0] AVG_LAST  = AVG_CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_SAR   = 2'd1,
        MODE_TRACK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    state_t               state_q, state_d;
    mode_t                cur_mode_q, cur_mode_d;
    mode_t                mode_in;
    logic                 comp_meta_q, comp_meta_d;
    logic                 comp_s_q, comp_s_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [BIT_W-1:0]     sar_bit_q, sar_bit_d;
    logic [N_BITS-1:0]    dac_q, dac_d;
    logic [N_BITS-1:0]    sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [AVG_CNT_W-1:0] avg_cnt_q, avg_cnt_d;
    logic [N_BITS-1:0]    avg_code_q, avg_code_d;
    logic                 avg_valid_q, avg_valid_d;

    logic                 run_req;
    logic                 clear_avg;
    logic [N_BITS-1:0]    code_nxt;
    logic [ACC_W-1:0]     acc_sum;

    assign mode_in = mode_t'(mode);

    function automatic logic [N_BITS-1:0] start_code(input mode_t m);
        return (m == MODE_RAMP) ? '0 : CODE_MID;
    endfunction

    always_comb begin
        state_d        = state_q;
        cur_mode_d     = cur_mode_q;
        comp_meta_d    = comp_in;
        comp_s_d       = comp_meta_q;
        step_d         = step_q;
        sar_bit_d      = sar_bit_q;
        dac_d          = dac_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        acc_d          = acc_q;
        avg_cnt_d      = avg_cnt_q;
        avg_code_d     = avg_code_q;
        avg_valid_d    = 1'b0;
        run_req        = enable && (mode_in != MODE_OFF);
        clear_avg      = 1'b1;
        code_nxt       = dac_q;
        acc_sum        = acc_q + ACC_W'(sample_q);

        case (state_q)
            ST_IDLE: begin
                dac_d  = '0;
                step_d = '0;
                if (run_req) begin
                    state_d    = ST_RUN;
                    cur_mode_d = mode_in;
                    dac_d      = start_code(mode_in);
                    sar_bit_d  = BIT_TOP;
                end
            end
            ST_RUN: begin
                if (!run_req) begin
                    state_d = ST_IDLE;
                    dac_d   = '0;
                    step_d  = '0;
                end else if (mode_in != cur_mode_q) begin
                    // Mode change outranks a coinciding decision: the aborted conversion emits nothing.
                    cur_mode_d = mode_in;
                    dac_d      = start_code(mode_in);
                    step_d     = '0;
                    sar_bit_d  = BIT_TOP;
                end else begin
                    clear_avg = 1'b0;
                    if (step_q != STEP_LAST) begin
                        step_d = step_q + STEP_W'(1);
                    end else begin
                        step_d = '0;
                        case (cur_mode_q)
                            MODE_RAMP: begin
                                if (comp_s_q) begin
                                    if (dac_q == CODE_MAX) begin
                                        sample_d       = CODE_MAX;
                                        sample_valid_d = 1'b1;
                                        dac_d          = '0;
                                    end else begin
                                        dac_d = dac_q + N_BITS'(1);
                                    end
                                end else begin
                                    sample_d       = (dac_q == '0) ? '0 : dac_q - N_BITS'(1);
                                    sample_valid_d = 1'b1;
                                    dac_d          = '0;
                                end
                            end
                            MODE_SAR: begin
                                code_nxt[sar_bit_q] = comp_s_q;
                                if (sar_bit_q == '0) begin
                                    sample_d       = code_nxt;
                                    sample_valid_d = 1'b1;
                                    dac_d          = CODE_MID;
                                    sar_bit_d      = BIT_TOP;
                                end else begin
                                    code_nxt[sar_bit_q - BIT_W'(1)] = 1'b1;
                                    dac_d     = code_nxt;
                                    sar_bit_d = sar_bit_q - BIT_W'(1);
                                end
                            end
                            MODE_TRACK: begin
                                if (comp_s_q) begin
                                    code_nxt = (dac_q == CODE_MAX) ? CODE_MAX : dac_q + N_BITS'(1);
                                end else begin
                                    code_nxt = (dac_q == '0) ? '0 : dac_q - N_BITS'(1);
                                end
                                dac_d          = code_nxt;
                                sample_d       = code_nxt;
                                sample_valid_d = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The averager consumes the registered sample, so its pulse trails sample_valid by one cycle.
        if (clear_avg) begin
            acc_d     = '0;
            avg_cnt_d = '0;
        end else if (sample_valid_q) begin
            if (avg_cnt_q == AVG_LAST) begin
                avg_code_d  = acc_sum[ACC_W-1:AVG_LOG2];
                avg_valid_d = 1'b1;
                acc_d       = '0;
                avg_cnt_d   = '0;
            end else begin
                acc_d     = acc_sum;
                avg_cnt_d = avg_cnt_q + AVG_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cur_mode_q     <= MODE_RAMP;
            comp_meta_q    <= 1'b0;
            comp_s_q       <= 1'b0;
            step_q         <= '0;
            sar_bit_q      <= '0;
            dac_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            acc_q          <= '0;
            avg_cnt_q      <= '0;
            avg_code_q     <= '0;
            avg_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_mode_q     <= cur_mode_d;
            comp_meta_q    <= comp_meta_d;
            comp_s_q       <= comp_s_d;
            step_q         <= step_d;
            sar_bit_q      <= sar_bit_d;
            dac_q          <= dac_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            acc_q          <= acc_d;
            avg_cnt_q      <= avg_cnt_d;
            avg_code_q     <= avg_code_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    assign dac_code     = dac_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign avg_code     = avg_code_q;
    assign avg_valid    = avg_valid_q;
    assign busy         = (state_q == ST_RUN);

endmodule

// File: tb/tb_r2r_adc_engine.sv
// Self-checking bench for r2r_adc_engine: an ideal comparator (dac_code < vin)
// closes the loop, and expected results come from an arithmetic reference model.
module tb_r2r_adc_engine;

    localparam int NB = 8;
    localparam int SD = 4;
    localparam int AL = 4;
    localparam int FULL = (1 << NB) - 1;
    localparam int MID  = 1 << (NB - 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic          comp_in;
    logic [NB-1:0] dac_code;
    logic [NB-1:0] sample;
    logic          sample_valid;
    logic [NB-1:0] avg_code;
    logic          avg_valid;
    logic          busy;

    int vin   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int md;
        int v;
        int exp_sample;
        int exp_lat;
    } vec_t;

    vec_t vecs[$];

    r2r_adc_engine #(
        .N_BITS  (NB),
        .STEP_DIV(SD),
        .AVG_LOG2(AL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .comp_in     (comp_in),
        .dac_code    (dac_code),
        .sample      (sample),
        .sample_valid(sample_valid),
        .avg_code    (avg_code),
        .avg_valid   (avg_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign comp_in = (int'(dac_code) < vin);

    // An ideal converter returns the largest code strictly below vin, clamped to the code range.
    function automatic int modelResult(input int v);
        if (v <= 0) return 0;
        if (v > FULL) return FULL;
        return v - 1;
    endfunction

    function automatic int modelLatency(input int md, input int v);
        int k;
        if (md == 1) return NB * SD;
        k = (v > FULL) ? FULL : ((v < 0) ? 0 : v);
        return (k + 1) * SD;
    endfunction

    // Binary search: the ladder code tried at step j of a successive-approximation conversion.
    function automatic int sarTrace(input int v, input int j);
        int code;
        int trial;
        code  = 0;
        trial = 0;
        for (int s = 0; s <= j; s++) begin
            trial = code | (1 << (NB - 1 - s));
            if (s < j && trial < v) code = trial;
        end
        return trial;
    endfunction

    function automatic int trackStep(input int code, input int v);
        if (code < v) return (code == FULL) ? FULL : code + 1;
        return (code == 0) ? 0 : code - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] md, input int v);
        enable = en;
        mode   = md;
        vin    = v;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, vin);
        tick();
        reset = 1'b0;
    endtask

    task automatic startRun(input int md, input int v, input string tag);
        doReset();
        applyStimulus(1'b1, md[1:0], v);
        tick();
        checkOutput($sformatf("%s busy", tag), busy, 1);
        checkOutput($sformatf("%s start code", tag), dac_code, (md == 0) ? 0 : MID);
    endtask

    task automatic waitSample(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            if (cyc < 0) begin
                tick();
                if (sample_valid) cyc = c;
            end
        end
    endtask

    task automatic addVec(input int md, input int v, input int s, input int l);
        vec_t t;
        t = '{md, v, s, l};
        vecs.push_back(t);
    endtask

    // Watches a running conversion for a fixed number of cycles, checking every sample and average.
    task automatic runMonitor(input int md, input int v, input int ncyc, input int period,
                              input int exp_samples, input int exp_avgs, input string tag);
        int model_code;
        int last;
        int nsamp;
        int navg;
        int msum;
        int mcnt;
        int avg_at;
        int avg_exp;
        int exp_s;
        model_code = MID;
        last = 0; nsamp = 0; navg = 0; msum = 0; mcnt = 0;
        avg_at = -1; avg_exp = 0; exp_s = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (sample_valid) begin
                nsamp++;
                if (md == 2) begin
                    model_code = trackStep(model_code, v);
                    exp_s = model_code;
                end else begin
                    exp_s = modelResult(v);
                end
                checkOutput($sformatf("%s sample#%0d", tag, nsamp), sample, exp_s);
                checkOutput($sformatf("%s interval#%0d", tag, nsamp), c - last, period);
                last = c;
                msum += exp_s;
                mcnt++;
                if (mcnt == (1 << AL)) begin
                    avg_at  = c + 1;
                    avg_exp = msum >> AL;
                    msum = 0;
                    mcnt = 0;
                end
            end
            if (avg_valid) begin
                navg++;
                checkOutput($sformatf("%s avg time", tag), c, avg_at);
                checkOutput($sformatf("%s avg code", tag), avg_code, avg_exp);
                avg_at = -1;
            end
        end
        checkOutput($sformatf("%s sample count", tag), nsamp, exp_samples);
        checkOutput($sformatf("%s avg count", tag), navg, exp_avgs);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int rv;
        int rm;

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 0);
        tick();
        tick();
        checkOutput("reset dac_code", dac_code, 0);
        checkOutput("reset sample", sample, 0);
        checkOutput("reset sample_valid", sample_valid, 0);
        checkOutput("reset avg_code", avg_code, 0);
        checkOutput("reset avg_valid", avg_valid, 0);
        checkOutput("reset busy", busy, 0);
        reset = 1'b0;
        tick();
        checkOutput("idle busy", busy, 0);

        applyStimulus(1'b1, 2'd3, 100);
        repeat (3) tick();
        checkOutput("mode3 busy", busy, 0);
        checkOutput("mode3 dac", dac_code, 0);

        addVec(1, 100, 99, 32);
        addVec(1, 101, 100, 32);
        addVec(1, 0, 0, 32);
        addVec(1, 300, 255, 32);
        addVec(0, 100, 99, 404);
        addVec(0, 0, 0, 4);
        addVec(0, 300, 255, 1024);
        addVec(0, 255, 254, 1024);
        for (int i = 0; i < 5; i++) begin
            rm = int'($urandom_range(0, 1));
            rv = int'($urandom_range(0, 270));
            addVec(rm, rv, modelResult(rv), modelLatency(rm, rv));
        end

        foreach (vecs[i]) begin
            startRun(vecs[i].md, vecs[i].v, $sformatf("vec%0d", i));
            waitSample(1100, cyc);
            checkOutput($sformatf("vec%0d latency", i), cyc, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d sample", i), sample, vecs[i].exp_sample);
            waitSample(1100, cyc);
            checkOutput($sformatf("vec%0d period", i), cyc, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d sample2", i), sample, vecs[i].exp_sample);
        end

        startRun(1, 100, "sar trace");
        for (int j = 0; j < NB; j++) begin
            checkOutput($sformatf("sar trace step%0d", j), dac_code, sarTrace(100, j));
            repeat (SD) tick();
        end
        checkOutput("sar trace valid", sample_valid, 1);
        checkOutput("sar trace sample", sample, 99);

        startRun(1, 100, "sar avg100");
        runMonitor(1, 100, 16 * 32 + 1, 32, 16, 1, "sar avg100");
        startRun(1, 101, "sar avg101");
        runMonitor(1, 101, 16 * 32 + 1, 32, 16, 1, "sar avg101");

        startRun(2, 100, "track");
        runMonitor(2, 100, 196, 4, 49, 3, "track");

        startRun(1, 100, "switch");
        runMonitor(1, 100, 5 * 32, 32, 5, 0, "switch sar");
        repeat (12) tick();
        checkOutput("switch bit4 code", dac_code, sarTrace(100, 3));
        applyStimulus(1'b1, 2'd0, 100);
        tick();
        checkOutput("switch dac zero", dac_code, 0);
        checkOutput("switch no sample", sample_valid, 0);
        runMonitor(0, 100, 16 * 404 + 1, 404, 16, 1, "switch ramp");

        startRun(1, 100, "simul");
        repeat (31) tick();
        applyStimulus(1'b1, 2'd2, 100);
        tick();
        checkOutput("simul no sample", sample_valid, 0);
        checkOutput("simul dac mid", dac_code, MID);
        runMonitor(2, 100, 65, 4, 16, 1, "simul track");

        startRun(0, 50, "rst");
        repeat (300) tick();
        reset = 1'b1;
        tick();
        checkOutput("rst dac", dac_code, 0);
        checkOutput("rst sample", sample, 0);
        checkOutput("rst sample_valid", sample_valid, 0);
        checkOutput("rst avg_code", avg_code, 0);
        checkOutput("rst avg_valid", avg_valid, 0);
        checkOutput("rst busy", busy, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 50);
        tick();
        checkOutput("rst idle busy", busy, 0);
        checkOutput("rst idle dac", dac_code, 0);
        applyStimulus(1'b1, 2'd0, 50);
        tick();
        checkOutput("rst restart busy", busy, 1);
        checkOutput("rst restart dac", dac_code, 0);
        runMonitor(0, 50, 204, 204, 1, 0, "rst cold");
        applyStimulus(1'b1, 2'd3, 50);
        tick();
        checkOutput("stop busy", busy, 0);
        checkOutput("stop dac", dac_code, 0);
        checkOutput("stop sample hold", sample, 49);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
